// File: rtl/alu_wb_pkg.sv
// alu_wb_pkg: shared constants and types for the ALU writeback buffer.
//   FLAG_*            bit positions of Z C N O inside the 4-bit flag word
//   ALU_WB_DEPTH      default FIFO depth
//   ALU_WB_DEST_W     default destination tag width
//   wb_entry_t        {data, dest} entry at the default tag width
package alu_wb_pkg;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    localparam int ALU_WB_DEPTH  = 4;
    localparam int ALU_WB_DEST_W = 3;

    typedef struct packed {
        logic [15:0]              data;
        logic [ALU_WB_DEST_W-1:0] dest;
    } wb_entry_t;
endpackage

// File: rtl/alu_wb_fifo.sv
// alu_wb_fifo: in-order entry storage with a registered head.
//   clk, rst_n         clock, async active-low reset
//   push, pop          write / consume strobes (pre-qualified by the caller)
//   hold_ld            load wdata/wdest into the head registers while the
//                      queue stays empty (keeps "last value" after a bypass)
//   wdata, wdest       entry to write
//   out_valid/out_data/out_dest   head entry, straight from flops
//   count, full        occupancy and full flag
module alu_wb_fifo #(
    parameter  int DEPTH  = 4,
    parameter  int DEST_W = 3,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              hold_ld,
    input  logic [15:0]       wdata,
    input  logic [DEST_W-1:0] wdest,
    output logic              out_valid,
    output logic [15:0]       out_data,
    output logic [DEST_W-1:0] out_dest,
    output logic [CNT_W-1:0]  count,
    output logic              full
);
    typedef struct packed {
        logic [15:0]       data;
        logic [DEST_W-1:0] dest;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               out_valid_q, out_valid_d;
    entry_t             out_q, out_d;
    entry_t             wr_entry;

    assign wr_entry = '{data: wdata, dest: wdest};

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = wr_entry;

        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Head registers track the entry at rd_ptr_d after this edge. If the
        // queue is empty once the pop is taken, that entry is the one being
        // written right now and is not yet in mem_q.
        out_d       = out_q;
        out_valid_d = (count_d != '0);
        if (count_d == '0) begin
            if (hold_ld) out_d = wr_entry;
        end else if (count_q == CNT_W'(pop)) begin
            out_d = wr_entry;
        end else begin
            out_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_q.data;
    assign out_dest  = out_q.dest;
    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));
endmodule

// File: rtl/alu_writeback_buffer.sv
// alu_writeback_buffer: buffers ALU results ahead of the register-file write
// port and owns the architectural Z C N O flag register.
//   Clock, Reset (async, active-low)
//   InValid/InReady    ALU result handshake; ALUOut, FlagsOut, WF, DestSel
//   OutValid/OutReady  register-file handshake; OutData, OutDest
//   Flags              architectural flags, written on accept when WF=1
//   Count              occupied entries
//   DropErr            sticky: a result was offered while InReady=0
// Optional build macro: ALU_WB_BYPASS_EN -- forwards the input straight to
// the output in the same cycle when the buffer is empty and OutReady=1.
module alu_writeback_buffer
    import alu_wb_pkg::*;
#(
    parameter int DEPTH  = ALU_WB_DEPTH,
    parameter int DEST_W = ALU_WB_DEST_W
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [15:0]                ALUOut,
    input  logic [3:0]                 FlagsOut,
    input  logic                       WF,
    input  logic [DEST_W-1:0]          DestSel,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [15:0]                OutData,
    output logic [DEST_W-1:0]          OutDest,
    output logic [3:0]                 Flags,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       DropErr
);
    logic                       full;
    logic                       accept;
    logic                       bypass;
    logic                       fifo_valid;
    logic [15:0]                fifo_data;
    logic [DEST_W-1:0]          fifo_dest;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic [3:0]                 flags_q, flags_d;
    logic                       drop_err_q, drop_err_d;

    // Ready depends only on occupancy: a full buffer refuses even when the
    // head is being drained this cycle.
    assign InReady = !full;
    assign accept  = InValid & InReady;

`ifdef ALU_WB_BYPASS_EN
    assign bypass = accept & OutReady & (count == '0);
`else
    assign bypass = 1'b0;
`endif

    alu_wb_fifo #(
        .DEPTH  (DEPTH),
        .DEST_W (DEST_W)
    ) u_fifo (
        .clk       (Clock),
        .rst_n     (Reset),
        .push      (accept & !bypass),
        .pop       (fifo_valid & OutReady),
        .hold_ld   (bypass),
        .wdata     (ALUOut),
        .wdest     (DestSel),
        .out_valid (fifo_valid),
        .out_data  (fifo_data),
        .out_dest  (fifo_dest),
        .count     (count),
        .full      (full)
    );

    always_comb begin
        flags_d    = flags_q;
        drop_err_d = drop_err_q | (InValid & !InReady);
        // A bypassed result is still an accepted result for flag purposes.
        if (accept && WF) flags_d = FlagsOut;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            flags_q    <= 4'b0000;
            drop_err_q <= 1'b0;
        end else begin
            flags_q    <= flags_d;
            drop_err_q <= drop_err_d;
        end
    end

    assign OutValid = fifo_valid | bypass;
    assign OutData  = bypass ? ALUOut  : fifo_data;
    assign OutDest  = bypass ? DestSel : fifo_dest;
    assign Flags    = flags_q;
    assign Count    = count;
    assign DropErr  = drop_err_q;
endmodule

// File: tb/tb_alu_writeback_buffer.sv
// tb_alu_writeback_buffer: directed plus randomized scoreboard bench.
// The driver keeps a queue of expected entries (the behavioural model of the
// buffer); a negedge monitor pops it whenever the DUT completes an output
// handshake and compares data, tag and stall stability.
module tb_alu_writeback_buffer;
    import alu_wb_pkg::*;

    localparam int DEPTH  = ALU_WB_DEPTH;
    localparam int DEST_W = ALU_WB_DEST_W;

    logic              Clock = 1'b0;
    logic              Reset = 1'b0;
    logic              InValid = 1'b0;
    logic              InReady;
    logic [15:0]       ALUOut = '0;
    logic [3:0]        FlagsOut = '0;
    logic              WF = 1'b0;
    logic [DEST_W-1:0] DestSel = '0;
    logic              OutValid;
    logic              OutReady = 1'b0;
    logic [15:0]       OutData;
    logic [DEST_W-1:0] OutDest;
    logic [3:0]        Flags;
    logic [$clog2(DEPTH+1)-1:0] Count;
    logic              DropErr;

    alu_writeback_buffer #(.DEPTH(DEPTH), .DEST_W(DEST_W)) dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .ALUOut(ALUOut), .FlagsOut(FlagsOut), .WF(WF), .DestSel(DestSel),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
        .OutDest(OutDest), .Flags(Flags), .Count(Count), .DropErr(DropErr)
    );

    always #5 Clock = ~Clock;

    int n_chk  = 0;
    int n_fail = 0;

    wb_entry_t         sb[$];
    int                occ = 0;
    logic [3:0]        exp_flags = '0;
    bit                exp_drop = 0;
    logic [15:0]       last_d = '0;
    logic [DEST_W-1:0] last_dest = '0;
    bit                prev_stall = 0;
    logic [15:0]       prev_d = '0;
    logic [DEST_W-1:0] prev_dest = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1: check state left by previous edges, drive one
    // cycle of stimulus, update the model, advance to the next posedge+1.
    task automatic step(input bit iv, input logic [15:0] d, input logic [3:0] f,
                        input bit wf, input logic [DEST_W-1:0] ds, input bit ordy);
        wb_entry_t e;
        chk("count", int'(Count), sb.size());
        chk("in_ready", int'(InReady), int'(sb.size() < DEPTH));
        chk("flags", int'(Flags), int'(exp_flags));
        chk("drop_err", int'(DropErr), int'(exp_drop));
        InValid = iv; ALUOut = d; FlagsOut = f; WF = wf; DestSel = ds; OutReady = ordy;
        occ = sb.size();
        if (iv) begin
            if (occ < DEPTH) begin
                if (wf) exp_flags = f;
                e.data = d;
                e.dest = ds;
                sb.push_back(e);
            end else begin
                exp_drop = 1;
            end
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input bit ordy);
        step(0, 16'h0, 4'h0, 0, '0, ordy);
    endtask

    // Monitor: checks outputs mid-cycle, when inputs and outputs are settled.
    initial begin
        wb_entry_t e;
        bit exp_v;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                exp_v = (occ > 0);
`ifdef ALU_WB_BYPASS_EN
                if (occ == 0 && InValid && OutReady) exp_v = 1;
`endif
                chk("out_valid", int'(OutValid), int'(exp_v));
                if (prev_stall) begin
                    chk("stall_valid", int'(OutValid), 1);
                    chk("stall_data", int'(OutData), int'(prev_d));
                    chk("stall_dest", int'(OutDest), int'(prev_dest));
                end
                if (OutValid && OutReady) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pop", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", int'(OutData), int'(e.data));
                        chk("out_dest", int'(OutDest), int'(e.dest));
                        last_d = e.data;
                        last_dest = e.dest;
                    end
                end else if (!OutValid) begin
                    chk("empty_hold_data", int'(OutData), int'(last_d));
                    chk("empty_hold_dest", int'(OutDest), int'(last_dest));
                end
                prev_stall = OutValid && !OutReady;
                prev_d = OutData;
                prev_dest = OutDest;
            end
        end
    end

    initial begin
        // Reset state
        #1;
        chk("rst_in_ready", int'(InReady), 1);
        chk("rst_count", int'(Count), 0);
        chk("rst_out_valid", int'(OutValid), 0);
        chk("rst_flags", int'(Flags), 0);
        chk("rst_out_data", int'(OutData), 0);
        chk("rst_drop", int'(DropErr), 0);
        @(posedge Clock);
        #1 Reset = 1'b1;

        // First result appears one cycle after acceptance, flags with it.
        step(1, 16'h1234, 4'b0100, 1, 3'd2, 0);
        chk("first_valid", int'(OutValid), 1);
        chk("first_data", int'(OutData), 16'h1234);
        chk("first_dest", int'(OutDest), 2);
        chk("first_flags", int'(Flags), 4'b0100);
        idle(1);
        idle(1);

        // Overfill with the output stalled, then drain in order.
        for (int i = 1; i <= 5; i++) step(1, 16'(i), 4'h0, 0, 3'(i), 0);
        chk("full_count", int'(Count), DEPTH);
        chk("full_ready", int'(InReady), 0);
        chk("drop_set", int'(DropErr), 1);
        for (int i = 0; i < DEPTH + 1; i++) idle(1);

        // WF=0 keeps flags, WF=1 writes them.
        step(1, 16'hA0A0, 4'b1010, 0, 3'd1, 1);
        chk("wf0_flags", int'(Flags), 4'b0100);
        step(1, 16'hB0B0, 4'b1000, 1, 3'd3, 1);
        chk("wf1_flags", int'(Flags), 4'b1000);
        idle(1);
        idle(1);

        // Two resident entries, then simultaneous push/pop across wrap.
        step(1, 16'h2001, 4'h0, 0, 3'd4, 0);
        step(1, 16'h2002, 4'h0, 0, 3'd5, 0);
        for (int i = 0; i < 10; i++) step(1, 16'(16'h3000 + i), 4'h0, 0, 3'(i), 1);
        chk("steady_count", int'(Count), 2);
        for (int i = 0; i < 3; i++) idle(1);

        // Stalled head stays put, then reset mid-stream.
        step(1, 16'hBEEF, 4'b0011, 1, 3'd6, 0);
        for (int i = 0; i < 5; i++) idle(0);
        chk("hold_data", int'(OutData), 16'hBEEF);
        chk("hold_valid", int'(OutValid), 1);
        InValid = 0;
        #2 Reset = 1'b0;
        #1;
        chk("arst_valid", int'(OutValid), 0);
        chk("arst_count", int'(Count), 0);
        chk("arst_flags", int'(Flags), 0);
        chk("arst_ready", int'(InReady), 1);
        chk("arst_drop", int'(DropErr), 0);
        sb.delete();
        occ = 0; exp_flags = '0; exp_drop = 0;
        last_d = '0; last_dest = '0; prev_stall = 0;
        @(posedge Clock);
        #1 Reset = 1'b1;

        // Empty buffer, output ready: same-cycle forward or one-cycle push.
        step(1, 16'h00FF, 4'b0001, 1, 3'd7, 1);
        chk("byp_flags", int'(Flags), 4'b0001);
        idle(1);
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, 16'($urandom), 4'($urandom),
                 1'($urandom), DEST_W'($urandom), $urandom_range(0, 9) < 6);
        for (int i = 0; i < DEPTH + 2; i++) idle(1);
        chk("final_empty", int'(Count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_writeback_buffer.md
# alu_writeback_buffer

- Sits directly downstream of the ALU.
- Accepts each ALU result (16-bit data, 4-bit flags, 3-bit destination tag) through a valid/ready handshake and holds it in a small in-order FIFO.
- Drains entries to the register-file write port through a second valid/ready handshake.
- Maintains the architectural flag register (Z C N O), updated in execution order whenever an accepted result carries WF=1.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- DEST_W, 3, destination-register tag width

Ports:
- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- InValid  in  1  ALU result present this cycle
- InReady  out  1  buffer can accept; equals !full
- ALUOut  in  16  result data
- FlagsOut  in  4  result flags, [3:0] = Z C N O
- WF  in  1  commit FlagsOut to Flags on accept
- DestSel  in  DEST_W  destination register tag
- OutValid  out  1  head entry present
- OutReady  in  1  register file accepts head
- OutData  out  16  head data
- OutDest  out  DEST_W  head tag
- Flags  out  4  architectural flag register Z C N O
- Count  out  $clog2(DEPTH+1)  occupied entries
- DropErr  out  1  sticky: InValid seen while InReady=0

## Operation
- Reset values:
  - Count=0, OutValid=0, OutData=0, OutDest=0
  - Flags=4'b0000, DropErr=0, InReady=1
  - Pointers at 0
- Push = InValid & InReady:
  - Writes {ALUOut, DestSel} at the write pointer; pointer wraps modulo DEPTH.
- Pop = OutValid & OutReady:
  - Advances the read pointer, modulo DEPTH.
- Flags is written with FlagsOut on the push edge when WF=1, and held otherwise.
  - A push with WF=0 leaves Flags unchanged.
  - Flags are not written while InReady=0.
- Count next value:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- Full (Count==DEPTH):
  - InReady=0 for the whole cycle, even if OutReady=1 that cycle; there is no same-cycle full pass-through.
  - InReady returns to 1 the cycle after a pop.
- Empty (Count==0): OutValid=0; OutData and OutDest hold their last values (0 after reset).
- DropErr:
  - Set on any cycle with InValid=1 & InReady=0.
  - The data is discarded and Flags are untouched.
  - Cleared only by Reset.
- OutValid must not be withdrawn, and OutData/OutDest must not change, while OutValid=1 & OutReady=0.
- Reset asserted mid-operation:
  - All entries are discarded immediately (asynchronous).
  - Outputs take their reset values without waiting for a clock edge.
  - Deassertion is synchronised externally.

## Timing
- Push-to-OutValid latency: 1 cycle. An entry pushed at edge N is visible on OutData after edge N.
- Flags are visible one cycle after the accepting edge.
- Throughput: one push and one pop per cycle in steady state.
- Output registers: OutValid, OutData and OutDest come directly from registers. InReady is decoded from Count only, with no combinational path from InValid or OutReady.

## Configuration
- ALU_WB_BYPASS_EN defined:
  - When Count==0, InValid=1 and OutReady=1, the input is forwarded combinationally to OutData/OutDest with OutValid=1 in the same cycle.
  - The entry is not written and Count stays 0.
  - Flags update as for a normal push.
  - With Count==0 and OutReady=0, it is a normal push.
- Not defined: no combinational input-to-output path; minimum latency is 1 cycle.

## Structure
- Package alu_wb_pkg holds:
  - flag index constants FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_O=0
  - a typedef for the entry struct {data[15:0], dest[DEST_W-1:0]}
  - default DEPTH and DEST_W
- Sub-module alu_wb_fifo: storage array, pointers, Count, full/empty.
- Top level: handshake logic, Flags register, DropErr, bypass mux.

## Test plan
- After reset:
  - Flags=0000, Count=0, OutValid=0, InReady=1.
  - Push ALUOut=16'h1234, DestSel=2, WF=1, FlagsOut=0100 → OutValid=1 next cycle, OutData=1234, OutDest=2, Flags=0100.
- OutReady=0; push 5 values 0x0001–0x0005:
  - Count reaches 4, InReady=0.
  - The 5th push sets DropErr=1.
  - Draining yields 1,2,3,4 in order, and InReady=1 after the first pop.
- Push with WF=0 and FlagsOut=1010 after Flags=0100 → Flags stays 0100. Next push with WF=1 and FlagsOut=1000 → Flags=1000.
- Count=2 with push and pop in the same cycle → Count stays 2 and order is preserved across pointer wrap over 10 such cycles.
- Hold OutReady=0 with head 0xBEEF for 5 cycles → OutData stable 0xBEEF, OutValid stable 1. Assert Reset mid-stream → OutValid=0, Count=0, Flags=0 immediately.
- With ALU_WB_BYPASS_EN: empty FIFO, InValid=1, OutReady=1, ALUOut=0x00FF → OutData=0x00FF with OutValid=1 in the same cycle, Count stays 0. Without the macro, the value appears one cycle later.
